// File: rtl/bcd_countdown_timer_pkg.sv
// Shared constants for the BCD countdown timer: state encodings and BCD limits.
package bcd_countdown_timer_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = DIGIT_W'(9);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_countdown_timer_digit.sv
// One BCD digit down counter with synchronous load, enable and borrow flag.
// Ports:
//   clk_tmp   - tick clock
//   rst_n     - asynchronous reset, active-high (loads RESET_VAL)
//   load      - load load_val this tick (wins over en)
//   load_val  - value to load
//   en        - decrement this tick (0 wraps to 9)
//   q         - registered digit value
//   borrow_c  - combinational: digit is 0, so a decrement here borrows
module bcd_digit_dn #(
  parameter int unsigned RESET_VAL = 0
) (
  input  logic       clk_tmp,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic [3:0] q,
  output logic       borrow_c
);
  import bcd_countdown_timer_pkg::*;

  localparam logic [DIGIT_W-1:0] RST_Q = DIGIT_W'(RESET_VAL);

  assign borrow_c = (q == '0);

  // Digit register: load has priority, decrement wraps 0 -> 9.
  always_ff @(posedge clk_tmp or posedge rst_n) begin
    if (rst_n) begin
      q <= RST_Q;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= borrow_c ? BCD_MAX : q - DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer with start/pause and reload requests.
// Ports:
//   clk_tmp     - divided tick clock, one rising edge per tick
//   rst_n       - asynchronous reset, active-high
//   start_pause - level; each rising edge is a start/pause request
//   reload      - level; each rising edge is a reload request
//   tens, ones  - BCD digits of the current count
//   running     - high in RUN
//   done        - high in DONE
module bcd_countdown_timer #(
  parameter int unsigned INIT_TENS = 3,
  parameter int unsigned INIT_ONES = 0
) (
  input  logic       clk_tmp,
  input  logic       rst_n,
  input  logic       start_pause,
  input  logic       reload,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       done
);
  import bcd_countdown_timer_pkg::*;

  localparam logic [DIGIT_W-1:0] INIT_T = DIGIT_W'(INIT_TENS);
  localparam logic [DIGIT_W-1:0] INIT_O = DIGIT_W'(INIT_ONES);

  // Elaboration-time range check of the preset digits.
  if (INIT_TENS > 32'(BCD_MAX)) begin : g_bad_tens
    $error("INIT_TENS must be a BCD digit (0-9)");
  end
  if (INIT_ONES > 32'(BCD_MAX)) begin : g_bad_ones
    $error("INIT_ONES must be a BCD digit (0-9)");
  end

  logic   start_prev, reload_prev;
  logic   start_edge, reload_edge;
  state_t state, state_nxt;
  logic   running_nxt, done_nxt;
  logic   dec_c, load_c;
  logic   ones_borrow, tens_borrow;
  logic   count_zero_c, count_one_c;

  // Request edges are registered, so the FSM acts one tick after detection.
  always_ff @(posedge clk_tmp or posedge rst_n) begin
    if (rst_n) begin
      start_prev  <= 1'b0;
      reload_prev <= 1'b0;
      start_edge  <= 1'b0;
      reload_edge <= 1'b0;
    end else begin
      start_prev  <= start_pause;
      reload_prev <= reload;
      start_edge  <= start_pause & ~start_prev;
      reload_edge <= reload & ~reload_prev;
    end
  end

  assign count_zero_c = tens_borrow & ones_borrow;
  assign count_one_c  = tens_borrow & (ones == DIGIT_W'(1));

  // State and status register.
  always_ff @(posedge clk_tmp or posedge rst_n) begin
    if (rst_n) begin
      state   <= IDLE;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= running_nxt;
      done    <= done_nxt;
    end
  end

  // Next state, counter controls; reload overrides any start request.
  always_comb begin
    state_nxt = state;
    dec_c     = 1'b0;
    load_c    = 1'b0;
    if (reload_edge) begin
      state_nxt = IDLE;
      load_c    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start_edge && !count_zero_c) state_nxt = RUN;
        end
        RUN: begin
          if (start_edge) begin
            state_nxt = PAUSE;
          end else if (!count_zero_c) begin
            dec_c = 1'b1;
            if (count_one_c) state_nxt = DONE;
          end
        end
        PAUSE: begin
          if (start_edge) state_nxt = RUN;
        end
        DONE: begin
          state_nxt = DONE;
        end
        default: state_nxt = IDLE;
      endcase
    end
    running_nxt = (state_nxt == RUN);
    done_nxt    = (state_nxt == DONE);
  end

  bcd_digit_dn #(.RESET_VAL(INIT_ONES)) u_ones (
    .clk_tmp  (clk_tmp),
    .rst_n    (rst_n),
    .load     (load_c),
    .load_val (INIT_O),
    .en       (dec_c),
    .q        (ones),
    .borrow_c (ones_borrow)
  );

  // Tens only steps when the ones digit borrows.
  bcd_digit_dn #(.RESET_VAL(INIT_TENS)) u_tens (
    .clk_tmp  (clk_tmp),
    .rst_n    (rst_n),
    .load     (load_c),
    .load_val (INIT_T),
    .en       (dec_c & ones_borrow),
    .q        (tens),
    .borrow_c (tens_borrow)
  );

endmodule

// File: doc/bcd_countdown_timer.md
BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 The block SHALL have parameter INIT_TENS, default 3, meaning preset tens digit (legal 0-9).
REQ-002 The block SHALL have parameter INIT_ONES, default 0, meaning preset ones digit (legal 0-9).
REQ-003 The block SHALL have port clk_tmp  input  1  clock: the divided tick clock from the upstream divider, one rising edge per timer tick.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port start_pause  input  1  level from the debounced button; each rising edge is one start/pause request.
REQ-006 The block SHALL have port reload  input  1  level; each rising edge is one reload request.
REQ-007 The block SHALL have port tens  output  4  BCD tens digit of the current count.
REQ-008 The block SHALL have port ones  output  4  BCD ones digit of the current count.
REQ-009 The block SHALL have port running  output  1  high while in state RUN.
REQ-010 The block SHALL have port done  output  1  high while in state DONE.

Function
REQ-011 The block SHALL detect a request edge as input==1 while its registered previous value==0, with the previous value sampled on every clk_tmp rising edge.
REQ-012 The block SHALL implement the FSM states IDLE, RUN, PAUSE and DONE, with all outputs registered.
REQ-013 IDLE: a start edge with count != 00 SHALL go to RUN; a start edge with count == 00 SHALL stay in IDLE; otherwise the count holds.
REQ-014 RUN: with no request, each tick SHALL decrement the count by one in BCD.
REQ-015 In RUN, a decrement from 01 to 00 SHALL enter DONE on the same edge.
REQ-016 RUN: a start edge SHALL go to PAUSE with no decrement on that edge.
REQ-017 PAUSE: the count SHALL hold; a start edge SHALL go to RUN, with the first decrement on the next tick.
REQ-018 DONE: the count SHALL hold at 00, and start edges SHALL be ignored.
REQ-019 A reload edge in any state SHALL load INIT_TENS/INIT_ONES and enter IDLE on the same edge.
REQ-020 A reload edge occurring together with a start edge SHALL take priority; the start edge is discarded.
REQ-021 BCD decrement: ones 1-9 SHALL go to ones-1; ones 0 SHALL go to 9 with tens-1; tens SHALL never leave 0-9.
REQ-022 The count SHALL never wrap below 00; 00 is reachable only as the terminal value entering DONE.
REQ-023 Latency: a request edge present at clk_tmp edge N SHALL be reflected in state and outputs after edge N+1, i.e. one tick of edge-detect registration.
REQ-024 Illegal parameter values (>9) SHALL be flagged by an elaboration-time check and are out of scope at runtime.

Reset
REQ-025 Asserting rst_n=1 SHALL force state IDLE, tens=INIT_TENS, ones=INIT_ONES, running=0, done=0, and both edge-detect registers to 0, independent of clk_tmp.
REQ-026 Reset mid-RUN or mid-PAUSE SHALL discard the count in progress, with no residual request pending after release.
REQ-027 If start_pause is held high through reset release, this SHALL produce one start edge on the first tick after release.

Structure
REQ-028 The state encodings (IDLE=0, RUN=1, PAUSE=2, DONE=3) and the BCD limit constant 9 SHALL reside in the shared lab constants package/header.
REQ-029 The single sub-module bcd_digit_dn SHALL be used: a one-digit BCD down counter with enable, load value and borrow-out, instantiated twice with the ones borrow enabling tens.
REQ-030 The top level SHALL contain only the edge detectors, the FSM and the instances; no clock other than clk_tmp SHALL be used.

Verification
REQ-031 The bench SHALL cover: reset, then one start edge, then 30 ticks -> count 30,29,...,01,00; done=1 and running=0 on the edge reaching 00.
REQ-032 The bench SHALL cover: start, run to 25, start edge -> PAUSE, hold 25 for 5 ticks; start edge -> 24 on the next tick after RUN is entered.
REQ-033 The bench SHALL cover: count 20 in RUN -> next tick 19, verifying the ones 0->9 borrow with tens 2->1.
REQ-034 The bench SHALL cover: in DONE, a start edge -> no change; a reload edge -> IDLE, 30, done=0.
REQ-035 The bench SHALL cover: simultaneous reload and start edges in RUN at count 12 -> IDLE, 30, running=0.
REQ-036 The bench SHALL cover: rst_n pulsed mid-cycle during RUN at 17 -> immediate 30, IDLE, outputs cleared, with no clk_tmp edge required.
